pc_unit: RTL and testbench

- Program-counter and next-PC stage of the single-cycle core; consumes branch/jump decode from the control unit and ALU/register/memory results.
- Holds the PC register and the N/Z status register used by status branches (BZ/BN/BALZ/BALN/BMZ/BMN/BRZ/BRN/BALRZ/BALRN).
- Produces fetch address, link address, and a misaligned-target trap with saved EPC.

---
 rtl/pc_unit.sv | 112 +++++++++++
 tb/tb_pc_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter, next-PC selection, N/Z status register and
// misaligned-target trap for the single-cycle core.
module pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_jump,
    input  logic        zero_branch,
    input  logic        need_zero,
    input  logic        status_branch,
    input  logic        need_st_Z,
    input  logic [1:0]  pc_select,
    input  logic [25:0] instr_imm,
    input  logic [31:0] reg_target,
    input  logic [31:0] mem_target,
    input  logic        alu_zero,
    input  logic [31:0] alu_result,
    input  logic        flags_we,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        taken,
    output logic        st_Z,
    output logic        st_N,
    output logic        addr_error,
    output logic [31:0] epc
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        st_z_q, st_z_d;
    logic        st_n_q, st_n_d;
    logic        addr_error_q, addr_error_d;

    logic [31:0] pc_inc;
    logic [31:0] branch_offset;
    logic [31:0] target;
    logic        cond_zero;
    logic        cond_stat;
    logic        taken_w;
    logic        misaligned;

    always_comb begin
        pc_inc        = pc_q + 32'd4;
        branch_offset = {{14{instr_imm[15]}}, instr_imm[15:0], 2'b00};

        case (pc_select)
            2'b00:   target = pc_inc + branch_offset;
            2'b01:   target = {pc_inc[31:28], instr_imm, 2'b00};
            2'b10:   target = reg_target;
            default: target = mem_target;
        endcase

        // Status branches see the flags as they stood before this cycle's ALU update.
        cond_zero  = zero_branch & (alu_zero == need_zero);
        cond_stat  = status_branch & (need_st_Z ? st_z_q : st_n_q);
        taken_w    = is_jump | cond_zero | cond_stat;
        misaligned = taken_w & (target[1:0] != 2'b00);
    end

    always_comb begin
        pc_d         = pc_q;
        epc_d        = epc_q;
        st_z_d       = st_z_q;
        st_n_d       = st_n_q;
        addr_error_d = 1'b0;

        if (!stall) begin
            if (misaligned) begin
                pc_d         = EXC_VECTOR;
                epc_d        = pc_q;
                addr_error_d = 1'b1;
            end else if (taken_w) begin
                pc_d = target;
            end else begin
                pc_d = pc_inc;
            end

            if (flags_we) begin
                st_z_d = (alu_result == 32'd0);
                st_n_d = alu_result[31];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            epc_q        <= 32'd0;
            st_z_q       <= 1'b0;
            st_n_q       <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            st_z_q       <= st_z_d;
            st_n_q       <= st_n_d;
            addr_error_q <= addr_error_d;
        end
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_inc;
    assign taken      = taken_w;
    assign st_Z       = st_z_q;
    assign st_N       = st_n_q;
    assign addr_error = addr_error_q;
    assign epc        = epc_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table plus randomized traffic for pc_unit,
// both checked against a behavioural model of the next-PC rules.
module tb_pc_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

    typedef struct {
        logic        reset;
        logic        stall;
        logic        is_jump;
        logic        zero_branch;
        logic        need_zero;
        logic        status_branch;
        logic        need_st_z;
        logic [1:0]  pc_select;
        logic [25:0] imm;
        logic [31:0] reg_t;
        logic [31:0] mem_t;
        logic        alu_zero;
        logic [31:0] alu_result;
        logic        flags_we;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic        exp_z;
        logic        exp_n;
        logic        exp_err;
        logic [31:0] exp_epc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        is_jump;
    logic        zero_branch;
    logic        need_zero;
    logic        status_branch;
    logic        need_st_Z;
    logic [1:0]  pc_select;
    logic [25:0] instr_imm;
    logic [31:0] reg_target;
    logic [31:0] mem_target;
    logic        alu_zero;
    logic [31:0] alu_result;
    logic        flags_we;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        st_Z;
    logic        st_N;
    logic        addr_error;
    logic [31:0] epc;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_z;
    logic        m_n;
    logic        m_err;
    logic        m_valid = 1'b0;
    logic        sampled_taken;

    pc_unit #(
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VECTOR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .is_jump      (is_jump),
        .zero_branch  (zero_branch),
        .need_zero    (need_zero),
        .status_branch(status_branch),
        .need_st_Z    (need_st_Z),
        .pc_select    (pc_select),
        .instr_imm    (instr_imm),
        .reg_target   (reg_target),
        .mem_target   (mem_target),
        .alu_zero     (alu_zero),
        .alu_result   (alu_result),
        .flags_we     (flags_we),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .taken        (taken),
        .st_Z         (st_Z),
        .st_N         (st_N),
        .addr_error   (addr_error),
        .epc          (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drives one cycle, checks combinational outputs mid-cycle, then registered ones after the edge.
    task automatic applyStimulus(input stim_t s, input int idx);
        logic [31:0] p4;
        logic [31:0] tgt;
        logic        tk;
        logic        mis;
        int          off;
        @(negedge clk);
        reset         = s.reset;
        stall         = s.stall;
        is_jump       = s.is_jump;
        zero_branch   = s.zero_branch;
        need_zero     = s.need_zero;
        status_branch = s.status_branch;
        need_st_Z     = s.need_st_z;
        pc_select     = s.pc_select;
        instr_imm     = s.imm;
        reg_target    = s.reg_t;
        mem_target    = s.mem_t;
        alu_zero      = s.alu_zero;
        alu_result    = s.alu_result;
        flags_we      = s.flags_we;
        #1;
        p4  = m_pc + 32'd4;
        off = int'($signed(s.imm[15:0]));
        case (s.pc_select)
            2'd0:    tgt = p4 + 32'(off * 4);
            2'd1:    tgt = (p4 & 32'hF000_0000) | (32'(s.imm) * 32'd4);
            2'd2:    tgt = s.reg_t;
            default: tgt = s.mem_t;
        endcase
        tk  = s.is_jump
            || (s.zero_branch && (s.alu_zero == s.need_zero))
            || (s.status_branch && (s.need_st_z ? m_z : m_n));
        mis = tk && (tgt % 4 != 0);
        sampled_taken = taken;
        if (m_valid) begin
            checkOutput("pc_plus4", idx, pc_plus4, p4);
            checkOutput("taken", idx, {31'd0, taken}, {31'd0, tk});
        end
        @(posedge clk);
        if (s.reset) begin
            m_pc    = RESET_PC;
            m_epc   = 32'd0;
            m_z     = 1'b0;
            m_n     = 1'b0;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else if (s.stall) begin
            m_err = 1'b0;
        end else begin
            if (mis) begin
                m_epc = m_pc;
                m_pc  = EXC_VECTOR;
                m_err = 1'b1;
            end else begin
                m_err = 1'b0;
                m_pc  = tk ? tgt : p4;
            end
            if (s.flags_we) begin
                m_z = (s.alu_result == 32'd0);
                m_n = s.alu_result[31];
            end
        end
        #1;
        if (m_valid) begin
            checkOutput("pc", idx, pc, m_pc);
            checkOutput("st_Z", idx, {31'd0, st_Z}, {31'd0, m_z});
            checkOutput("st_N", idx, {31'd0, st_N}, {31'd0, m_n});
            checkOutput("addr_error", idx, {31'd0, addr_error}, {31'd0, m_err});
            checkOutput("epc", idx, epc, m_epc);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t jreg(input logic [31:0] a);
        stim_t s;
        s = idle();
        s.is_jump   = 1'b1;
        s.pc_select = 2'd2;
        s.reg_t     = a;
        return s;
    endfunction

    function automatic vec_t mk(input stim_t s, input logic t, input logic [31:0] p,
                                input logic z, input logic n, input logic e,
                                input logic [31:0] ep);
        vec_t v;
        v.s = s; v.exp_taken = t; v.exp_pc = p;
        v.exp_z = z; v.exp_n = n; v.exp_err = e; v.exp_epc = ep;
        return v;
    endfunction

    initial begin
        vec_t  vecs[$];
        stim_t s;

        reset = 1'b0; stall = 1'b0; is_jump = 1'b0; zero_branch = 1'b0;
        need_zero = 1'b0; status_branch = 1'b0; need_st_Z = 1'b0;
        pc_select = 2'd0; instr_imm = '0; reg_target = '0; mem_target = '0;
        alu_zero = 1'b0; alu_result = '0; flags_we = 1'b0;
        m_pc = '0; m_epc = '0; m_z = 1'b0; m_n = 1'b0; m_err = 1'b0;

        s = idle(); s.reset = 1'b1;
        vecs.push_back(mk(s, 0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(idle(), 0, 32'h4, 0, 0, 0, 32'h0));
        vecs.push_back(mk(idle(), 0, 32'h8, 0, 0, 0, 32'h0));
        vecs.push_back(mk(idle(), 0, 32'hC, 0, 0, 0, 32'h0));
        vecs.push_back(mk(jreg(32'h100), 1, 32'h100, 0, 0, 0, 32'h0));
        s = idle(); s.zero_branch = 1; s.need_zero = 1; s.alu_zero = 1; s.imm = 26'h000FFFE;
        vecs.push_back(mk(s, 1, 32'hFC, 0, 0, 0, 32'h0));
        vecs.push_back(mk(jreg(32'h100), 1, 32'h100, 0, 0, 0, 32'h0));
        s.alu_zero = 0;
        vecs.push_back(mk(s, 0, 32'h104, 0, 0, 0, 32'h0));
        s = idle(); s.flags_we = 1; s.alu_result = 32'h8000_0000;
        vecs.push_back(mk(s, 0, 32'h108, 0, 1, 0, 32'h0));
        vecs.push_back(mk(jreg(32'h1000_0010), 1, 32'h1000_0010, 0, 1, 0, 32'h0));
        s = idle(); s.status_branch = 1; s.need_st_z = 0; s.pc_select = 2'd1; s.imm = 26'h40;
        vecs.push_back(mk(s, 1, 32'h1000_0100, 0, 1, 0, 32'h0));
        vecs.push_back(mk(jreg(32'h1000_0010), 1, 32'h1000_0010, 0, 1, 0, 32'h0));
        s.need_st_z = 1;
        vecs.push_back(mk(s, 0, 32'h1000_0014, 0, 1, 0, 32'h0));
        s = idle(); s.flags_we = 1; s.alu_result = 32'h0; s.status_branch = 1; s.need_st_z = 1;
        vecs.push_back(mk(s, 0, 32'h1000_0018, 1, 0, 0, 32'h0));
        vecs.push_back(mk(jreg(32'h40), 1, 32'h40, 1, 0, 0, 32'h0));
        vecs.push_back(mk(jreg(32'h203), 1, 32'h80, 1, 0, 1, 32'h40));
        vecs.push_back(mk(idle(), 0, 32'h84, 1, 0, 0, 32'h40));
        s = idle(); s.is_jump = 1; s.pc_select = 2'd3; s.mem_t = 32'h200;
        vecs.push_back(mk(s, 1, 32'h200, 1, 0, 0, 32'h40));
        s = jreg(32'h300); s.stall = 1; s.flags_we = 1; s.alu_result = 32'h8000_0000;
        vecs.push_back(mk(s, 1, 32'h200, 1, 0, 0, 32'h40));
        vecs.push_back(mk(s, 1, 32'h200, 1, 0, 0, 32'h40));
        vecs.push_back(mk(jreg(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 1, 0, 0, 32'h40));
        vecs.push_back(mk(idle(), 0, 32'h0, 1, 0, 0, 32'h40));
        vecs.push_back(mk(idle(), 0, 32'h4, 1, 0, 0, 32'h40));
        vecs.push_back(mk(jreg(32'h2), 1, 32'h80, 1, 0, 1, 32'h4));
        vecs.push_back(mk(jreg(32'h203), 1, 32'h80, 1, 0, 1, 32'h80));
        s = idle(); s.zero_branch = 1; s.need_zero = 1; s.alu_zero = 0;
        s.pc_select = 2'd2; s.reg_t = 32'h3;
        vecs.push_back(mk(s, 0, 32'h84, 1, 0, 0, 32'h80));
        vecs.push_back(mk(jreg(32'h1), 1, 32'h80, 1, 0, 1, 32'h84));
        s = idle(); s.reset = 1; s.stall = 1;
        vecs.push_back(mk(s, 0, RESET_PC, 0, 0, 0, 32'h0));
        vecs.push_back(mk(jreg(32'h3), 1, 32'h80, 0, 0, 1, 32'h0));
        s = idle(); s.stall = 1;
        vecs.push_back(mk(s, 0, 32'h80, 0, 0, 0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s, i);
            checkOutput("tbl_taken", i, {31'd0, sampled_taken}, {31'd0, vecs[i].exp_taken});
            checkOutput("tbl_pc", i, pc, vecs[i].exp_pc);
            checkOutput("tbl_st_Z", i, {31'd0, st_Z}, {31'd0, vecs[i].exp_z});
            checkOutput("tbl_st_N", i, {31'd0, st_N}, {31'd0, vecs[i].exp_n});
            checkOutput("tbl_addr_error", i, {31'd0, addr_error}, {31'd0, vecs[i].exp_err});
            checkOutput("tbl_epc", i, epc, vecs[i].exp_epc);
        end

        for (int i = 0; i < 500; i++) begin
            s = idle();
            s.reset         = ($urandom_range(0, 49) == 0);
            s.stall         = ($urandom_range(0, 7) == 0);
            s.is_jump       = ($urandom_range(0, 5) == 0);
            s.zero_branch   = 1'($urandom);
            s.need_zero     = 1'($urandom);
            s.status_branch = 1'($urandom);
            s.need_st_z     = 1'($urandom);
            s.pc_select     = 2'($urandom);
            s.imm           = 26'($urandom);
            s.reg_t         = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            s.mem_t         = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            s.alu_zero      = 1'($urandom);
            s.alu_result    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            s.flags_we      = 1'($urandom);
            applyStimulus(s, 1000 + i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
